// File: rtl/cdc_mmio_bridge_pkg.sv
// Shared constants for the CPU-side MMIO bridge to the USB CDC byte streams.
package cdc_mmio_bridge_pkg;

  // Word register indices on addr_i
  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2,
    RegLevel  = 2'd3
  } reg_idx_e;

  // STATUS bit positions
  localparam int unsigned StRxEmpty     = 0;
  localparam int unsigned StRxFull      = 1;
  localparam int unsigned StTxEmpty     = 2;
  localparam int unsigned StTxFull      = 3;
  localparam int unsigned StTxOverflow  = 4;
  localparam int unsigned StRxUnderflow = 5;

  // CTRL field offsets
  localparam int unsigned CtrlRxIrqEn  = 0;
  localparam int unsigned CtrlTxIrqEn  = 1;
  localparam int unsigned CtrlRxThresh = 8;
  localparam int unsigned CtrlTxThresh = 16;

  // LEVEL field offsets
  localparam int unsigned LvlRx = 0;
  localparam int unsigned LvlTx = 16;

  // Marks a DATA read that actually returned a byte
  localparam int unsigned DataValidBit = 31;

endpackage

// File: rtl/cdc_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an explicit level counter.
// Callers must not push when full or pop when empty.
module cdc_mmio_bridge_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     head_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [LvlW-1:0]   level_q, level_d;

  // Storage is not reset; pointers and level define what is valid
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointer and level next-state; simultaneous push and pop leaves level unchanged
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_i) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push_i && !pop_i) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_i && pop_i) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // Pointer and level state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/cdc_mmio_bridge.sv
// MMIO bridge between the CPU load/store path and the USB CDC byte streams:
// RX FIFO (host to CPU), TX FIFO (CPU to host), status, sticky errors, threshold irqs.
module cdc_mmio_bridge
  import cdc_mmio_bridge_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sel_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [1:0]        addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              rx_irq_o,
  output logic              tx_irq_o,
  output logic [DATA_W-1:0] in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i,
  input  logic [DATA_W-1:0] out_data_i,
  input  logic              out_valid_i,
  output logic              out_ready_o
);

  localparam int unsigned LvlW = DEPTH_LOG2 + 1;

  reg_idx_e          reg_idx;
  logic              acc_wr, acc_rd;
  logic              data_wr, data_rd;

  logic [DATA_W-1:0] rx_head, tx_head;
  logic [LvlW-1:0]   rx_level, tx_level;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              rx_push, rx_pop, tx_push, tx_pop;

  logic [31:0]       data_q, data_d;
  logic [31:0]       rd_data;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_unf_q, rx_unf_d;
  logic              rx_irq_en_q, rx_irq_en_d;
  logic              tx_irq_en_q, tx_irq_en_d;
  logic [LvlW-1:0]   rx_thresh_q, rx_thresh_d;
  logic [LvlW-1:0]   tx_thresh_q, tx_thresh_d;
  logic [LvlW-1:0]   rx_thresh_eff;
  logic              rx_irq_q, rx_irq_d;
  logic              tx_irq_q, tx_irq_d;
  logic              unused_data_i;

  // Write has priority: read+write in one cycle is a pure write
  assign reg_idx = reg_idx_e'(addr_i);
  assign acc_wr  = sel_i & write_i;
  assign acc_rd  = sel_i & read_i & ~write_i;
  assign data_wr = acc_wr & (reg_idx == RegData);
  assign data_rd = acc_rd & (reg_idx == RegData);

  assign unused_data_i = ^data_i;

  // Stream handshakes and FIFO strobes; fullness/emptiness are start-of-cycle values
  assign out_ready_o = ~rx_full;
  assign rx_push     = out_valid_i & ~rx_full;
  assign rx_pop      = data_rd & ~rx_empty;
  assign tx_push     = data_wr & ~tx_full;
  assign tx_pop      = ~tx_empty & in_ready_i;
  assign in_valid_o  = ~tx_empty;
  assign in_data_o   = tx_head;

  cdc_mmio_bridge_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (rx_push),
    .data_i  (out_data_i),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .level_o (rx_level),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  cdc_mmio_bridge_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (tx_push),
    .data_i  (data_i[DATA_W-1:0]),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .level_o (tx_level),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // Read mux over the pre-edge register and FIFO state
  always_comb begin
    rd_data = '0;
    unique case (reg_idx)
      RegData: begin
        if (!rx_empty) begin
          rd_data[DataValidBit] = 1'b1;
          rd_data[DATA_W-1:0]   = rx_head;
        end
      end
      RegStatus: begin
        rd_data[StRxEmpty]     = rx_empty;
        rd_data[StRxFull]      = rx_full;
        rd_data[StTxEmpty]     = tx_empty;
        rd_data[StTxFull]      = tx_full;
        rd_data[StTxOverflow]  = tx_ovf_q;
        rd_data[StRxUnderflow] = rx_unf_q;
      end
      RegCtrl: begin
        rd_data[CtrlRxIrqEn]          = rx_irq_en_q;
        rd_data[CtrlTxIrqEn]          = tx_irq_en_q;
        rd_data[CtrlRxThresh +: LvlW] = rx_thresh_q;
        rd_data[CtrlTxThresh +: LvlW] = tx_thresh_q;
      end
      RegLevel: begin
        rd_data[LvlRx +: LvlW] = rx_level;
        rd_data[LvlTx +: LvlW] = tx_level;
      end
      default: rd_data = '0;
    endcase
  end

  // Register next-state: read data, sticky flags (set beats clear), CTRL, irqs
  always_comb begin
    data_d      = data_q;
    tx_ovf_d    = tx_ovf_q;
    rx_unf_d    = rx_unf_q;
    rx_irq_en_d = rx_irq_en_q;
    tx_irq_en_d = tx_irq_en_q;
    rx_thresh_d = rx_thresh_q;
    tx_thresh_d = tx_thresh_q;

    if (acc_rd) begin
      data_d = rd_data;
    end

    if (acc_wr && (reg_idx == RegStatus)) begin
      if (data_i[StTxOverflow]) begin
        tx_ovf_d = 1'b0;
      end
      if (data_i[StRxUnderflow]) begin
        rx_unf_d = 1'b0;
      end
    end
    if (data_wr && tx_full) begin
      tx_ovf_d = 1'b1;
    end
    if (data_rd && rx_empty) begin
      rx_unf_d = 1'b1;
    end

    if (acc_wr && (reg_idx == RegCtrl)) begin
      rx_irq_en_d = data_i[CtrlRxIrqEn];
      tx_irq_en_d = data_i[CtrlTxIrqEn];
      rx_thresh_d = data_i[CtrlRxThresh +: LvlW];
      tx_thresh_d = data_i[CtrlTxThresh +: LvlW];
    end

    // A zero RX threshold behaves as one so an empty FIFO never interrupts
    rx_thresh_eff = (rx_thresh_q == '0) ? LvlW'(1) : rx_thresh_q;
    rx_irq_d      = rx_irq_en_q & (rx_level >= rx_thresh_eff);
    tx_irq_d      = tx_irq_en_q & (tx_level <= tx_thresh_q);
  end

  // Register state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q      <= '0;
      tx_ovf_q    <= 1'b0;
      rx_unf_q    <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      rx_thresh_q <= LvlW'(1);
      tx_thresh_q <= '0;
      rx_irq_q    <= 1'b0;
      tx_irq_q    <= 1'b0;
    end else begin
      data_q      <= data_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_unf_q    <= rx_unf_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
      rx_thresh_q <= rx_thresh_d;
      tx_thresh_q <= tx_thresh_d;
      rx_irq_q    <= rx_irq_d;
      tx_irq_q    <= tx_irq_d;
    end
  end

  assign data_o   = data_q;
  assign rx_irq_o = rx_irq_q;
  assign tx_irq_o = tx_irq_q;

endmodule
